ff_sync_multi: RTL
==================

# ff_sync_multi

Parametrised multi-channel synchronizer and glitch filter. It is the successor of the two-flop `ff_sync`, and lives in the destination (`clk_b`) domain. It brings WIDTH asynchronous level signals in through a configurable-depth flop chain. A per-channel stability filter then rejects pulses shorter than FILTER cycles. The block emits clean levels, one-cycle rise/fall pulses and, optionally, saturating per-channel transition counters.

## Interface
Parameters:
- `WIDTH`, 4: number of independent channels (≥1).
- `STAGES`, 2: synchronizer flop depth per channel (≥2).
- `FILTER`, 3: consecutive cycles a new synced value must persist before it is accepted (≥1).
- `CNT_W`, 8: width of each transition counter (≥1).

Ports:
- `clk_b`  in  1  destination clock; the only clock.
- `rst_b`  in  1  asynchronous, active-high reset.
- `sig_a`  in  WIDTH  asynchronous input levels; no timing relation to `clk_b`.
- `cnt_clr`  in  1  synchronous clear of all transition counters.
- `sig_b`  out  WIDTH  filtered, synchronized level per channel.
- `rise_b`  out  WIDTH  one-cycle pulse when `sig_b[i]` goes 0→1.
- `fall_b`  out  WIDTH  one-cycle pulse when `sig_b[i]` goes 1→0.
- `cnt_b`  out  WIDTH*CNT_W  packed counters; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- **Synchronizer:** per channel, a shift chain of STAGES flops clocked by `clk_b`. The last flop output is `s[i]`. No logic sits between chain flops.
- **Filter:** per channel, a stability counter `stab[i]` of width clog2(FILTER+1).
  - If `s[i] == sig_b[i]`: `stab[i]` ← 0.
  - Else, if `stab[i] == FILTER-1`: `sig_b[i]` ← `s[i]`, `stab[i]` ← 0, and the matching rise/fall pulse registers high.
  - Else: `stab[i]` ← `stab[i]`+1.
- **Glitch rejection:** a value at `s[i]` shorter than FILTER cycles never reaches `sig_b[i]`. Its counter restarts from 0 when `s[i]` returns to the held level.
- **Pulses:** `rise_b`/`fall_b` are registered and high for exactly one cycle, coincident with the `sig_b` update. `rise_b[i]` and `fall_b[i]` are never both high.
- **Channels:** fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- **Counters** (when configured in):
  - `cnt_b[i]` increments by 1 on each cycle where `rise_b[i]|fall_b[i]` is being set.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - `cnt_clr` has priority: a clear and a transition in the same cycle leave the counter at 0.
- **Reset:** asserting `rst_b` immediately clears all chain flops, `stab`, `sig_b`, `rise_b`, `fall_b` and `cnt_b` to 0. This holds mid-filter too; no pulse is emitted for a discarded partial count.

## Timing
- Reset value of every output: 0.
- Latency: a `sig_a[i]` change sampled at `clk_b` edge k appears on `s[i]` after edge k+STAGES−1, and on `sig_b[i]` (with its pulse) after edge k+STAGES+FILTER−1.
  - Defaults: `sig_b` updates after edge k+4.
- After reset release with `sig_a[i]`=1, the channel behaves as a 0→1 step: `rise_b[i]` fires at the normal latency from the first sampling edge.
- An input toggling faster than FILTER `clk_b` cycles holds `sig_b` at its last accepted value indefinitely.
- `cnt_b` updates in the same cycle as the pulse.

## Configuration
- **`FF_SYNC_EDGE_CNT_EN` defined:** the counters and `cnt_clr` logic are built as described.
- **`FF_SYNC_EDGE_CNT_EN` not defined:**
  - No counter flops are instantiated.
  - `cnt_b` is tied to all-zeros.
  - `cnt_clr` is ignored.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, STAGES=2, FILTER=3, CNT_W=8 unless noted.
- **Reset with inputs high:** hold `rst_b`=1 with `sig_a`=4'hF → all outputs 0. Release before edge k → `sig_b`=4'hF after edge k+4, `rise_b`=4'hF for one cycle, each counter = 1.
- **Level step and return:** `sig_a[1]` 0→1 stable before edge k → `sig_b[1]`=1 and `rise_b[1]`=1 only in the cycle after edge k+4. Then 1→0 → `fall_b[1]` one cycle, `cnt_b[1]`=2.
- **Glitch rejection:** `sig_a[0]` high for exactly 2 `clk_b` cycles → `sig_b[0]` stays 0, no pulses, `cnt_b[0]`=0. A third test holds it high 3 cycles → accepted.
- **Saturation and clear:** CNT_W=3; 10 slow toggles on channel 2 → `cnt_b[2]`=7. Assert `cnt_clr` in the same cycle as a transition → counter 0, and the pulse still occurs.
- **Reset mid-filter:** assert `rst_b` asynchronously while `stab[3]`=2 → outputs clear immediately, and no `rise_b[3]` appears before the post-release latency.
- **Parameter sweep:** STAGES=3, FILTER=1 → `sig_b` updates after edge k+3. Build without `FF_SYNC_EDGE_CNT_EN` → `cnt_b` is constantly 0 while pulses are unchanged.

Source files
------------

// File: rtl/ff_sync_multi.sv
// Multi-channel clk_b-domain synchronizer with a per-channel stability filter and edge pulses.
// Define FF_SYNC_EDGE_CNT_EN to build saturating per-channel transition counters; otherwise cnt_b is zero.
module ff_sync_multi #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int FILTER = 3,
  parameter int CNT_W  = 8
) (
  input  logic                   clk_b,
  input  logic                   rst_b,
  input  logic [WIDTH-1:0]       sig_a,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       sig_b,
  output logic [WIDTH-1:0]       rise_b,
  output logic [WIDTH-1:0]       fall_b,
  output logic [WIDTH*CNT_W-1:0] cnt_b
);

  localparam int                STAB_W   = $clog2(FILTER + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILTER - 1);

  // chain_q[0] captures sig_a; chain_q[STAGES-1] is the synchronized value
  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             s;

  logic [WIDTH-1:0][STAB_W-1:0] stab_q, stab_d;
  logic [WIDTH-1:0]             sig_q, sig_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], sig_a};
    end
  end

  assign s = chain_q[STAGES-1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stab_d = stab_q;
    sig_d  = sig_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == sig_q[i]) begin
        stab_d[i] = '0;
      end else if (stab_q[i] == STAB_MAX) begin
        sig_d[i]  = s[i];
        stab_d[i] = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        stab_d[i] = stab_q[i] + STAB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      stab_q <= '0;
      sig_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      stab_q <= stab_d;
      sig_q  <= sig_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sig_b  = sig_q;
  assign rise_b = rise_q;
  assign fall_b = fall_q;

`ifdef FF_SYNC_EDGE_CNT_EN
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a coincident transition; counts stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if ((rise_d[i] | fall_d[i]) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_b = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_b          = '0;
`endif

endmodule
